// File: rtl/cb_doutb_map.sv
// rtl/cb_doutb_map.sv - CB port-B read lane mapper onto the RSA operand bus
// Delays read control by the BRAM latency, re-lanes doutb, and flags the last beat of each row burst.
module cb_doutb_map #(
  parameter int X       = 4,
  parameter int L       = 4,
  parameter int RSA_DW  = 16,
  parameter int ROW_LEN = 10,
  parameter int RD_LAT  = 1
) (
  input  logic                  clk,
  input  logic                  sys_rst,
  input  logic                  CB_enb,
  input  logic [1:0]            CB_doutb_sel,
  input  logic                  l_k_0,
  input  logic [L*RSA_DW-1:0]   CB_doutb,
  output logic [X*RSA_DW-1:0]   A_CB_doutb,
  output logic                  A_CB_doutb_vld,
  output logic                  A_CB_doutb_last
);

  localparam int MINXL = (X < L) ? X : L;
  localparam int CW    = $clog2(ROW_LEN);

  localparam logic [1:0] SEL_POS = 2'b01;
  localparam logic [1:0] SEL_NEG = 2'b10;
  localparam logic [1:0] SEL_NEW = 2'b11;

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  logic [RD_LAT-1:0]      en_pipe_q;
  logic [RD_LAT-1:0][1:0] sel_pipe_q;
  logic [RD_LAT-1:0]      lk_pipe_q;

  logic [CW-1:0] cnt_q;
  state_t        state_q;

  logic                 en_d;
  logic [1:0]           sel_d;
  logic                 lk_d;
  logic                 beat_vld_d;
  logic                 wrap_d;
  logic [CW-1:0]        cnt_inc_d;
  logic [X*RSA_DW-1:0]  data_d;

  // Last pipeline stage lines up with the data that read produced.
  assign en_d       = en_pipe_q[RD_LAT-1];
  assign sel_d      = sel_pipe_q[RD_LAT-1];
  assign lk_d       = lk_pipe_q[RD_LAT-1];
  assign beat_vld_d = en_d && (sel_d != 2'b00);

  for (genvar i = 0; i < X; i++) begin : g_lane
    logic [RSA_DW-1:0] pos_w;
    logic [RSA_DW-1:0] neg_w;
    logic [RSA_DW-1:0] new_w;
    logic [RSA_DW-1:0] lane_w;

    if (i < MINXL) begin : g_fwd
      assign pos_w = CB_doutb[i*RSA_DW +: RSA_DW];
      assign neg_w = CB_doutb[(L-1-i)*RSA_DW +: RSA_DW];
    end else begin : g_fwd_zero
      assign pos_w = '0;
      assign neg_w = '0;
    end

    // New-landmark mode pulls one lane pair: lower pair when lk is set, upper pair otherwise.
    if (i == 0) begin : g_new0
      assign new_w = lk_d ? CB_doutb[0 +: RSA_DW] : CB_doutb[2*RSA_DW +: RSA_DW];
    end else if (i == 1) begin : g_new1
      assign new_w = lk_d ? CB_doutb[RSA_DW +: RSA_DW] : CB_doutb[3*RSA_DW +: RSA_DW];
    end else begin : g_new_zero
      assign new_w = '0;
    end

    always_comb begin
      lane_w = '0;
      case (sel_d)
        SEL_POS: lane_w = pos_w;
        SEL_NEG: lane_w = neg_w;
        SEL_NEW: lane_w = new_w;
        default: lane_w = '0;
      endcase
    end

    assign data_d[i*RSA_DW +: RSA_DW] = lane_w;
  end

  assign wrap_d    = (state_q == S_STREAM) && (cnt_q == CW'(ROW_LEN - 1));
  assign cnt_inc_d = (state_q == S_IDLE) ? CW'(1) : cnt_q + CW'(1);

  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      en_pipe_q       <= '0;
      sel_pipe_q      <= '0;
      lk_pipe_q       <= '0;
      A_CB_doutb      <= '0;
      A_CB_doutb_vld  <= 1'b0;
      A_CB_doutb_last <= 1'b0;
      cnt_q           <= '0;
      state_q         <= S_IDLE;
    end else begin
      en_pipe_q[0]  <= CB_enb;
      sel_pipe_q[0] <= CB_doutb_sel;
      lk_pipe_q[0]  <= l_k_0;
      for (int k = 1; k < RD_LAT; k++) begin
        en_pipe_q[k]  <= en_pipe_q[k-1];
        sel_pipe_q[k] <= sel_pipe_q[k-1];
        lk_pipe_q[k]  <= lk_pipe_q[k-1];
      end

      if (beat_vld_d) begin
        A_CB_doutb      <= data_d;
        A_CB_doutb_vld  <= 1'b1;
        A_CB_doutb_last <= wrap_d;
        if (wrap_d) begin
          cnt_q   <= '0;
          state_q <= S_IDLE;
        end else begin
          cnt_q   <= cnt_inc_d;
          state_q <= S_STREAM;
        end
      end else begin
        // Any gap restarts the burst.
        A_CB_doutb      <= '0;
        A_CB_doutb_vld  <= 1'b0;
        A_CB_doutb_last <= 1'b0;
        cnt_q           <= '0;
        state_q         <= S_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_cb_doutb_map.sv
// tb/tb_cb_doutb_map.sv - scoreboard bench for cb_doutb_map
module tb_cb_doutb_map;

  localparam int X = 4, L = 4, DW = 16, ROW_LEN = 10, RD_LAT = 1;
  localparam int OW = X*DW + 2;

  logic              clk = 1'b0;
  logic              sys_rst;
  logic              CB_enb;
  logic [1:0]        CB_doutb_sel;
  logic              l_k_0;
  logic [L*DW-1:0]   CB_doutb;
  logic [X*DW-1:0]   A_CB_doutb;
  logic              A_CB_doutb_vld;
  logic              A_CB_doutb_last;

  always #5 clk = ~clk;

  cb_doutb_map #(.X(X), .L(L), .RSA_DW(DW), .ROW_LEN(ROW_LEN), .RD_LAT(RD_LAT)) dut (
    .clk             (clk),
    .sys_rst         (sys_rst),
    .CB_enb          (CB_enb),
    .CB_doutb_sel    (CB_doutb_sel),
    .l_k_0           (l_k_0),
    .CB_doutb        (CB_doutb),
    .A_CB_doutb      (A_CB_doutb),
    .A_CB_doutb_vld  (A_CB_doutb_vld),
    .A_CB_doutb_last (A_CB_doutb_last)
  );

  int checks = 0;
  int errors = 0;
  int cnt_m  = 0;

  logic [OW-1:0] exp_q[$];
  string         tag_q[$];

  logic          prev_en;
  logic [63:0]   prev_data;

  function automatic logic [63:0] map_f(input logic [1:0] sel, input logic lk, input logic [63:0] d);
    case (sel)
      2'b01:   return d;
      2'b10:   return {d[15:0], d[31:16], d[47:32], d[63:48]};
      2'b11:   return lk ? {32'h0, d[31:0]} : {32'h0, d[63:32]};
      default: return 64'h0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step(input logic en, input logic [1:0] sel, input logic lk,
                      input logic [63:0] data, input string tag);
    logic          v;
    logic          la;
    logic [OW-1:0] e;
    @(negedge clk);
    CB_enb       = en;
    CB_doutb_sel = sel;
    l_k_0        = lk;
    CB_doutb     = prev_en ? prev_data : {$urandom, $urandom};
    prev_en      = en;
    prev_data    = data;
    v = en && (sel != 2'b00);
    if (v) begin
      la    = (cnt_m == ROW_LEN - 1);
      cnt_m = la ? 0 : cnt_m + 1;
    end else begin
      la    = 1'b0;
      cnt_m = 0;
    end
    exp_q.push_back({v ? map_f(sel, lk, data) : 64'h0, v, la});
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    if (exp_q.size() > 1) begin
      e = exp_q.pop_front();
      check(tag_q.pop_front(), {A_CB_doutb, A_CB_doutb_vld, A_CB_doutb_last}, e);
    end
  endtask

  task automatic hold_reset(input int n);
    sys_rst = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      CB_enb       = 1'b1;
      CB_doutb_sel = 2'($urandom_range(1, 3));
      l_k_0        = 1'($urandom);
      CB_doutb     = {$urandom, $urandom};
      @(posedge clk);
      #1;
      check("in_reset", {A_CB_doutb, A_CB_doutb_vld, A_CB_doutb_last}, '0);
    end
    @(negedge clk);
    sys_rst      = 1'b1;
    CB_enb       = 1'b0;
    CB_doutb_sel = 2'b00;
    prev_en      = 1'b0;
    cnt_m        = 0;
    exp_q.delete();
    tag_q.delete();
    exp_q.push_back('0);
    tag_q.push_back("first_after_reset");
  endtask

  initial begin
    sys_rst      = 1'b0;
    CB_enb       = 1'b0;
    CB_doutb_sel = 2'b00;
    l_k_0        = 1'b0;
    CB_doutb     = '0;
    prev_en      = 1'b0;
    prev_data    = '0;

    hold_reset(4);

    step(1'b1, 2'b01, 1'b0, 64'h0004_0003_0002_0001, "pos_first");
    step(1'b0, 2'b00, 1'b0, 64'h0, "idle");
    step(1'b0, 2'b00, 1'b0, 64'h0, "idle");

    step(1'b1, 2'b10, 1'b0, 64'h0004_0003_0002_0001, "neg");
    step(1'b1, 2'b11, 1'b1, 64'hDDDD_CCCC_BBBB_AAAA, "new_lk1");
    step(1'b1, 2'b11, 1'b0, 64'hDDDD_CCCC_BBBB_AAAA, "new_lk0");
    step(1'b0, 2'b00, 1'b0, 64'h0, "idle");
    step(1'b0, 2'b00, 1'b0, 64'h0, "idle");

    for (int i = 0; i < 25; i++)
      step(1'b1, 2'b01, 1'b0, {$urandom, $urandom}, $sformatf("burst25_beat%0d", i + 1));
    step(1'b0, 2'b00, 1'b0, 64'h0, "burst_end");
    step(1'b0, 2'b00, 1'b0, 64'h0, "idle");

    for (int i = 0; i < 6; i++)
      step(1'b1, 2'(1 + (i % 3)), 1'($urandom), {$urandom, $urandom}, $sformatf("pregap_beat%0d", i + 1));
    step(1'b0, 2'b01, 1'b0, 64'h0, "gap");
    for (int i = 0; i < 10; i++)
      step(1'b1, 2'b01, 1'b0, {$urandom, $urandom}, $sformatf("postgap_beat%0d", i + 1));
    for (int i = 0; i < 4; i++)
      step(1'b1, 2'b10, 1'b0, {$urandom, $urandom}, $sformatf("presel_beat%0d", i + 1));
    step(1'b1, 2'b00, 1'b1, {$urandom, $urandom}, "sel_idle_gap");
    for (int i = 0; i < 10; i++)
      step(1'b1, 2'($urandom_range(1, 3)), 1'($urandom), {$urandom, $urandom},
           $sformatf("mixed_beat%0d", i + 1));
    step(1'b0, 2'b00, 1'b0, 64'h0, "idle");
    step(1'b0, 2'b00, 1'b0, 64'h0, "idle");

    for (int i = 0; i < 6; i++)
      step(1'b1, 2'b01, 1'b0, {$urandom, $urandom}, $sformatf("prereset_beat%0d", i + 1));
    #2;
    sys_rst = 1'b0;
    #1;
    check("async_clear", {A_CB_doutb, A_CB_doutb_vld, A_CB_doutb_last}, '0);
    hold_reset(2);
    for (int i = 0; i < 10; i++)
      step(1'b1, 2'b01, 1'b0, {$urandom, $urandom}, $sformatf("postreset_beat%0d", i + 1));
    step(1'b0, 2'b00, 1'b0, 64'h0, "idle");
    step(1'b0, 2'b00, 1'b0, 64'h0, "idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
